// File: rtl/wifi_phy_pkg.sv
// Shared types and constants for the WIFI TX byte streamer.
package wifi_phy_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        DONE
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BIDX_W         = $clog2(BYTES_PER_WORD);
    // Byte counter must also hold the value BYTES_PER_WORD itself.
    localparam int BCNT_W         = BIDX_W + 1;

    // Bytes carried by the final word of a frame: the low length bits,
    // or a full word when the length is a multiple of the word size.
    function automatic logic [BCNT_W-1:0] tail_bytes(input logic [BIDX_W-1:0] lo);
        return (lo == '0) ? BCNT_W'(BYTES_PER_WORD) : BCNT_W'(lo);
    endfunction

endpackage

// File: rtl/wifi_tx_byte_streamer_if.sv
// Control, TX-buffer read port and PHY byte handshake of the streamer.
interface wifi_tx_byte_streamer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_FIFO  = 8,
    parameter int LEN_W      = ADDR_FIFO + 2
);
    logic                  start;
    logic                  abort;
    logic [ADDR_FIFO-1:0]  start_addr;
    logic [LEN_W-1:0]      frame_len;
    logic [ADDR_FIFO-1:0]  buf_addr;
    logic                  buf_rden;
    logic [DATA_WIDTH-1:0] buf_rdata;
    logic [7:0]            tx_byte;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_last;
    logic                  busy;
    logic                  done;

    // The streamer itself.
    modport master (
        input  start, abort, start_addr, frame_len, buf_rdata, tx_ready,
        output buf_addr, buf_rden, tx_byte, tx_valid, tx_last, busy, done
    );

    // Whoever controls it, serves the buffer and consumes bytes.
    modport slave (
        output start, abort, start_addr, frame_len, buf_rdata, tx_ready,
        input  buf_addr, buf_rden, tx_byte, tx_valid, tx_last, busy, done
    );
endinterface

// File: rtl/wifi_tx_prefetch.sv
// One-entry word holding register between the buffer read port and the
// byte shifter; lets the next word be fetched while the current one streams.
module wifi_tx_prefetch #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_word,
    input  logic                  pop,
    output logic                  vld,
    output logic [DATA_WIDTH-1:0] word
);

    // Entry fills from returning read data and empties when handed to the shifter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld  <= 1'b0;
            word <= '0;
        end else if (flush) begin
            vld  <= 1'b0;
        end else if (load) begin
            vld  <= 1'b1;
            word <= load_word;
        end else if (pop) begin
            vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/wifi_tx_byte_streamer.sv
// Reads a frame from the TX buffer RAM and streams it little-endian, one
// byte per handshake, to the PHY. Holds FSM, word counters and address gen.
module wifi_tx_byte_streamer
    import wifi_phy_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_FIFO  = 8,
    parameter int LEN_W      = ADDR_FIFO + 2
) (
    input  logic                    clk,
    input  logic                    reset,
    wifi_tx_byte_streamer_if.master bus
);

    // Word counts reach 2^(LEN_W-2), which needs LEN_W-1 bits.
    localparam int WCNT_W = LEN_W - 1;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] cur_word, cur_word_n, src_word, pf_word;
    logic [BCNT_W-1:0]     cur_cnt, cur_cnt_n, tail;
    logic                  cur_last, cur_last_n;
    logic                  tx_valid, tx_last, busy, done;
    logic                  rden, rvld, pf_vld;
    logic [ADDR_FIFO-1:0]  addr;
    logic [WCNT_W-1:0]     rd_left, ld_left, words;
    logic                  hs, active, accept, cur_free;
    logic                  load_cur, pf_load, pf_pop, issue;

    assign words = {1'b0, bus.frame_len[LEN_W-1:2]} + WCNT_W'(|bus.frame_len[1:0]);

    assign bus.buf_addr = addr;
    assign bus.buf_rden = rden;
    assign bus.tx_byte  = cur_word[7:0];
    assign bus.tx_valid = tx_valid;
    assign bus.tx_last  = tx_last;
    assign bus.busy     = busy;
    assign bus.done     = done;

    wifi_tx_prefetch #(.DATA_WIDTH(DATA_WIDTH)) u_prefetch (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.abort),
        .load      (pf_load),
        .load_word (bus.buf_rdata),
        .pop       (pf_pop),
        .vld       (pf_vld),
        .word      (pf_word)
    );

    // Handshake, word movement and read-issue decisions for this cycle.
    always_comb begin
        hs       = tx_valid && bus.tx_ready;
        active   = (state == FILL) || (state == STREAM);
        accept   = (state == IDLE) && bus.start && !bus.abort && (bus.frame_len != '0);
        cur_free = (cur_cnt == '0) || (hs && (cur_cnt == BCNT_W'(1)));
        // Returning data bypasses an empty prefetch entry to keep first-byte latency short.
        load_cur = active && !bus.abort && cur_free && (pf_vld || rvld) && (ld_left != '0);
        src_word = pf_vld ? pf_word : bus.buf_rdata;
        pf_pop   = load_cur && pf_vld;
        pf_load  = active && !bus.abort && rvld && !(load_cur && !pf_vld);
        // A read is only issued with nothing in flight and a free prefetch slot,
        // so its data always has somewhere to land.
        issue    = active && !bus.abort && (rd_left != '0) && !rden && !rvld && !pf_vld;
    end

    // Next state; abort overrides everything.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = (bus.frame_len == '0) ? DONE : FILL;
            FILL:    if (load_cur) state_n = STREAM;
            STREAM:  if (hs && tx_last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (bus.abort) state_n = IDLE;
    end

    // Byte shifter: shift on handshake, reload when the current word is spent.
    always_comb begin
        cur_word_n = cur_word;
        cur_cnt_n  = cur_cnt;
        cur_last_n = cur_last;
        if (hs) begin
            cur_word_n = cur_word >> 8;
            cur_cnt_n  = cur_cnt - BCNT_W'(1);
        end
        if (load_cur) begin
            cur_word_n = src_word;
            cur_last_n = (ld_left == WCNT_W'(1));
            cur_cnt_n  = cur_last_n ? tail : BCNT_W'(BYTES_PER_WORD);
        end
        if (bus.abort) begin
            cur_cnt_n  = '0;
            cur_last_n = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Registered outputs, shifter, counters and buffer read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            cur_word <= '0;
            cur_cnt  <= '0;
            cur_last <= 1'b0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            rden     <= 1'b0;
            rvld     <= 1'b0;
            addr     <= '0;
            rd_left  <= '0;
            ld_left  <= '0;
            tail     <= '0;
        end else begin
            busy     <= (state_n == FILL) || (state_n == STREAM);
            done     <= (state_n == DONE);
            cur_word <= cur_word_n;
            cur_cnt  <= cur_cnt_n;
            cur_last <= cur_last_n;
            tx_valid <= (cur_cnt_n != '0);
            tx_last  <= cur_last_n && (cur_cnt_n == BCNT_W'(1));
            rvld     <= rden && !bus.abort;
            if (accept) begin
                rden    <= 1'b1;
                addr    <= bus.start_addr;
                rd_left <= words - WCNT_W'(1);
                ld_left <= words;
                tail    <= tail_bytes(bus.frame_len[BIDX_W-1:0]);
            end else if (issue) begin
                rden    <= 1'b1;
                addr    <= addr + ADDR_FIFO'(1);
                rd_left <= rd_left - WCNT_W'(1);
            end else begin
                rden    <= 1'b0;
            end
            if (load_cur) ld_left <= ld_left - WCNT_W'(1);
            if (bus.abort) begin
                rden    <= 1'b0;
                rd_left <= '0;
                ld_left <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wifi_tx_byte_streamer.sv
// Directed bench for wifi_tx_byte_streamer: buffer RAM model, byte and
// read-address scoreboards, handshake-hold and timing checks.
module tb_wifi_tx_byte_streamer;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_checks = 0;

    logic [31:0] mem [256];
    logic [8:0]  exp_q [$];
    logic [7:0]  addr_q [$];

    int   hs_total = 0, rd_total = 0, done_total = 0;
    int   hs_mark = 0, first_hs_cyc = 0, last_hs_cyc = 0, done_cyc = 0;
    bit   rand_ready = 0;
    bit   prev_stall = 0;
    logic [7:0] prev_byte = '0;
    logic       prev_last = 1'b0;

    wifi_tx_byte_streamer_if bus ();

    wifi_tx_byte_streamer dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer RAM: one-cycle read latency, garbage on the bus when not reading.
    always @(posedge clk) begin
        if (bus.buf_rden) bus.buf_rdata <= mem[bus.buf_addr];
        else              bus.buf_rdata <= $urandom();
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Output monitor: byte scoreboard, read-address scoreboard, stall hold, done.
    always @(negedge clk) begin
        logic [8:0] e;
        if (bus.tx_valid && bus.tx_ready) begin
            if (hs_total == hs_mark) first_hs_cyc = cyc;
            hs_total++;
            chk("byte_avail", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("tx_byte", bus.tx_byte, e[7:0]);
                chk("tx_last", bus.tx_last, e[8]);
            end
            if (bus.tx_last) last_hs_cyc = cyc;
        end
        if (prev_stall)
            chk("stall_hold", {bus.tx_valid, bus.tx_last, bus.tx_byte}, {1'b1, prev_last, prev_byte});
        prev_stall = bus.tx_valid && !bus.tx_ready;
        prev_byte  = bus.tx_byte;
        prev_last  = bus.tx_last;
        if (bus.buf_rden) begin
            rd_total++;
            chk("read_avail", addr_q.size() > 0, 1);
            if (addr_q.size() > 0) chk("buf_addr", bus.buf_addr, addr_q.pop_front());
        end
        if (bus.done) begin
            done_total++;
            done_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) bus.tx_ready = ($urandom_range(0, 9) < 3);
    endtask

    task automatic push_frame(input logic [7:0] addr, input int len);
        logic [31:0] w;
        logic [7:0]  a;
        for (int i = 0; i < len; i++) begin
            a = addr + 8'(i / 4);
            w = mem[a];
            exp_q.push_back({(i == len - 1), w[8*(i%4) +: 8]});
        end
        for (int k = 0; k < (len + 3) / 4; k++) begin
            a = addr + 8'(k);
            addr_q.push_back(a);
        end
    endtask

    task automatic run_frame(input logic [7:0] addr, input int len, input bit poke);
        int base_done, base_rd, base_hs, c;
        push_frame(addr, len);
        base_done = done_total;
        base_rd   = rd_total;
        base_hs   = hs_total;
        hs_mark   = hs_total;
        bus.start      = 1'b1;
        bus.start_addr = addr;
        bus.frame_len  = 10'(len);
        step();
        bus.start = 1'b0;
        if (len != 0) begin
            chk("rden_latency", bus.buf_rden, 1);
            chk("first_addr", bus.buf_addr, addr);
            step();
            chk("valid_not_early", bus.tx_valid, 0);
            step();
            chk("valid_latency", bus.tx_valid, 1);
        end else begin
            chk("zero_len_rden", bus.buf_rden, 0);
            chk("zero_len_busy", bus.busy, 0);
            chk("zero_len_done", bus.done, 1);
        end
        c = 0;
        while (done_total == base_done && c < 4000) begin
            step();
            c++;
            if (poke) begin
                if (c == 2) begin
                    bus.start      = 1'b1;
                    bus.start_addr = 8'h80;
                    bus.frame_len  = 10'd4;
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        step();
        chk("done_one_cycle", bus.done, 0);
        chk("busy_after_done", bus.busy, 0);
        step();
        step();
        chk("done_count", done_total - base_done, 1);
        chk("bytes_pending", exp_q.size(), 0);
        chk("reads_pending", addr_q.size(), 0);
        chk("read_count", rd_total - base_rd, (len + 3) / 4);
        chk("byte_count", hs_total - base_hs, len);
        if (len != 0) chk("done_after_last", done_cyc, last_hs_cyc + 1);
        if (len != 0 && !rand_ready) chk("gap_free", last_hs_cyc - first_hs_cyc, len - 1);
    endtask

    initial begin
        int base_hs, base_done, c;
        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        mem[0] = 32'h4433_2211;
        mem[1] = 32'h8877_6655;

        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.start_addr = '0;
        bus.frame_len  = '0;
        bus.tx_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_tx_last", bus.tx_last, 0);
        chk("rst_tx_byte", bus.tx_byte, 0);
        chk("rst_buf_rden", bus.buf_rden, 0);
        chk("rst_buf_addr", bus.buf_addr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        rst_n = 1'b1;
        step();

        // Two full words, then a partial tail, then an address wrap.
        run_frame(8'h00, 8, 0);
        run_frame(8'h00, 5, 0);
        run_frame(8'hFF, 8, 0);
        run_frame(8'h10, 16, 0);

        // Back-pressure from the PHY.
        rand_ready = 1;
        run_frame(8'h20, 37, 0);
        rand_ready = 0;
        bus.tx_ready = 1'b1;

        // Abort while byte 3 of a 12-byte frame is on the bus.
        push_frame(8'h40, 12);
        base_hs   = hs_total;
        base_done = done_total;
        bus.start      = 1'b1;
        bus.start_addr = 8'h40;
        bus.frame_len  = 10'd12;
        step();
        bus.start = 1'b0;
        c = 0;
        while (hs_total - base_hs < 3 && c < 200) begin
            step();
            c++;
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_valid", bus.tx_valid, 0);
        chk("abort_rden", bus.buf_rden, 0);
        chk("abort_busy", bus.busy, 0);
        exp_q.delete();
        addr_q.delete();
        repeat (5) step();
        chk("abort_no_done", done_total - base_done, 0);
        chk("abort_no_bytes", hs_total - base_hs, 4);

        // Same frame from byte 0, with a start pulse while busy.
        run_frame(8'h40, 12, 1);

        // Asynchronous reset in the middle of a frame.
        push_frame(8'h60, 20);
        bus.start      = 1'b1;
        bus.start_addr = 8'h60;
        bus.frame_len  = 10'd20;
        step();
        bus.start = 1'b0;
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        chk("areset_valid", bus.tx_valid, 0);
        chk("areset_busy", bus.busy, 0);
        chk("areset_rden", bus.buf_rden, 0);
        exp_q.delete();
        addr_q.delete();
        step();
        rst_n = 1'b1;
        step();

        // Zero-length frame: done pulse only.
        run_frame(8'h50, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
